// File: rtl/vote_ctrl_pkg.sv
// vote_ctrl_pkg: shared FSM state type and qualification popcount helper for the vote controller
package vote_ctrl_pkg;
  typedef enum logic {ST_IDLE, ST_LOCKOUT} state_t;
  localparam int MAX_BUTTONS = 32;
  function automatic int onehot_count(input logic [MAX_BUTTONS-1:0] v);
    int n;
    n = 0;
    for (int i = 0; i < MAX_BUTTONS; i++) n += int'(v[i]);
    return n;
  endfunction
endpackage

// File: rtl/button_debounce_ch.sv
// button_debounce_ch: per-button hold counter that flags one qualification cycle per press
module button_debounce_ch #(
  parameter int HOLD_CYCLES = 10,
  parameter int CNT_W = $clog2(HOLD_CYCLES + 2)
) (
  input  logic clock,
  input  logic reset,
  input  logic enable,
  input  logic button,
  output logic qual
);
  logic [CNT_W-1:0] cnt;
  // Saturating one past HOLD_CYCLES keeps a held button from qualifying again
  always_ff @(posedge clock or posedge reset)
    if (reset) cnt <= '0;
    else cnt <= (!enable || !button) ? '0 :
                (cnt < CNT_W'(HOLD_CYCLES + 1)) ? cnt + 1'b1 : cnt;
  assign qual = cnt == CNT_W'(HOLD_CYCLES);
endmodule

// File: rtl/multi_button_vote_ctrl.sv
// multi_button_vote_ctrl: debounced multi-candidate vote validator with conflict rejection and post-vote lockout
module multi_button_vote_ctrl
  import vote_ctrl_pkg::*;
#(
  parameter int NUM_BUTTONS = 4,
  parameter int HOLD_CYCLES = 10,
  parameter int LOCKOUT_CYCLES = 16,
  parameter int REQUIRE_EXCLUSIVE = 1,
  parameter int COUNT_W = 16,
  localparam int ID_W = $clog2(NUM_BUTTONS)
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   enable,
  input  logic [NUM_BUTTONS-1:0] button,
  output logic                   valid_vote,
  output logic [ID_W-1:0]        vote_id,
  output logic                   conflict,
  output logic                   busy,
  output logic [COUNT_W-1:0]     vote_count
);
  localparam int CNT_W = $clog2(HOLD_CYCLES + 2);
  localparam int LK_W = LOCKOUT_CYCLES > 0 ? $clog2(LOCKOUT_CYCLES + 1) : 1;
  logic [NUM_BUTTONS-1:0] qual;
  for (genvar g = 0; g < NUM_BUTTONS; g++) begin : g_ch
    button_debounce_ch #(.HOLD_CYCLES(HOLD_CYCLES), .CNT_W(CNT_W)) u_ch (
      .clock(clock), .reset(reset), .enable(enable), .button(button[g]), .qual(qual[g])
    );
  end
  state_t state, state_nx;
  logic [LK_W-1:0] lk_cnt, lk_nx;
  int n_qual;
  logic excl_bad, vote_d, conflict_d;
  logic [ID_W-1:0] id_d;
  // With a single qual bit, any other raised button makes the press ambiguous
  always_comb begin
    n_qual = onehot_count(MAX_BUTTONS'(qual));
    excl_bad = (REQUIRE_EXCLUSIVE != 0) && |(button & ~qual);
    conflict_d = enable && (n_qual > 1 || (n_qual == 1 && excl_bad));
    vote_d = enable && n_qual == 1 && !excl_bad && state == ST_IDLE;
    id_d = '0;
    for (int i = 0; i < NUM_BUTTONS; i++) if (qual[i]) id_d = ID_W'(i);
  end
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      state <= ST_IDLE;
      lk_cnt <= '0;
    end else begin
      state <= state_nx;
      lk_cnt <= lk_nx;
    end
  always_comb begin
    state_nx = (state == ST_IDLE) ? ((vote_d && LOCKOUT_CYCLES > 0) ? ST_LOCKOUT : ST_IDLE) :
               (lk_cnt == LK_W'(1)) ? ST_IDLE : ST_LOCKOUT;
    lk_nx = (state == ST_IDLE) ? ((state_nx == ST_LOCKOUT) ? LK_W'(LOCKOUT_CYCLES) : lk_cnt) :
            lk_cnt - 1'b1;
  end
  always_comb busy = state == ST_LOCKOUT;
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      valid_vote <= 1'b0;
      conflict <= 1'b0;
      vote_id <= '0;
      vote_count <= '0;
    end else begin
      valid_vote <= vote_d;
      conflict <= conflict_d;
      vote_id <= vote_d ? id_d : '0;
      vote_count <= (vote_d && vote_count != '1) ? vote_count + 1'b1 : vote_count;
    end
endmodule

// File: tb/tb_multi_button_vote_ctrl.sv
// tb_multi_button_vote_ctrl: directed vector and corner-sequence bench for the vote controller
module tb_multi_button_vote_ctrl;
  logic clock = 1'b0, reset = 1'b1, enable = 1'b1;
  logic [3:0] button = '0;
  logic valid_vote, conflict, busy, valid_vote_b, conflict_b, busy_b;
  logic [1:0] vote_id, vote_id_b;
  logic [15:0] vote_count, vote_count_b;
  int checks = 0, failures = 0;
  int cyc, nv, nc, nb, vid, vcyc, ccyc, nv_b, vid_b, nc_b;
  int both = 0, id_bad = 0;
  typedef struct {
    logic [3:0] btn;
    int hold;
    int e_nv;
    int e_id;
    int e_nc;
    int e_busy;
    int e_cyc;
  } vec_t;
  vec_t vt[6];

  multi_button_vote_ctrl dut (
    .clock(clock), .reset(reset), .enable(enable), .button(button),
    .valid_vote(valid_vote), .vote_id(vote_id), .conflict(conflict), .busy(busy), .vote_count(vote_count)
  );
  multi_button_vote_ctrl #(.REQUIRE_EXCLUSIVE(0)) dut_b (
    .clock(clock), .reset(reset), .enable(enable), .button(button),
    .valid_vote(valid_vote_b), .vote_id(vote_id_b), .conflict(conflict_b), .busy(busy_b),
    .vote_count(vote_count_b)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic clr();
    cyc = 0; nv = 0; nc = 0; nb = 0; vid = 0; vcyc = 0; ccyc = 0; nv_b = 0; vid_b = 0; nc_b = 0;
  endtask

  task automatic tick();
    @(negedge clock);
    cyc++;
    if (valid_vote) begin
      nv++;
      vid = int'(vote_id);
      if (vcyc == 0) vcyc = cyc;
    end
    if (conflict) begin
      nc++;
      if (ccyc == 0) ccyc = cyc;
    end
    if (busy) nb++;
    if (valid_vote_b) begin
      nv_b++;
      vid_b = int'(vote_id_b);
    end
    if (conflict_b) nc_b++;
    if (valid_vote && conflict) both++;
    if (!valid_vote && vote_id != 2'd0) id_bad++;
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  task automatic do_reset();
    @(negedge clock);
    button = '0;
    enable = 1'b1;
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    clr();
  endtask

  initial begin
    vt[0] = '{4'b0100, 15, 1, 2, 0, 16, 11};
    vt[1] = '{4'b0001, 10, 1, 0, 0, 16, 11};
    vt[2] = '{4'b0001,  9, 0, 0, 0,  0,  0};
    vt[3] = '{4'b1010, 12, 0, 0, 1,  0, 11};
    vt[4] = '{4'b0111, 12, 0, 0, 1,  0, 11};
    vt[5] = '{4'b1000,  1, 0, 0, 0,  0,  0};
    @(negedge clock);
    chk("rst_valid", int'(valid_vote), 0);
    chk("rst_conflict", int'(conflict), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_count", int'(vote_count), 0);
    for (int i = 0; i < 6; i++) begin
      do_reset();
      button = vt[i].btn;
      ticks(vt[i].hold);
      button = '0;
      ticks(30);
      chk($sformatf("v%0d_votes", i), nv, vt[i].e_nv);
      chk($sformatf("v%0d_id", i), vid, vt[i].e_id);
      chk($sformatf("v%0d_conflicts", i), nc, vt[i].e_nc);
      chk($sformatf("v%0d_busy_cycles", i), nb, vt[i].e_busy);
      chk($sformatf("v%0d_event_cycle", i), vcyc + ccyc, vt[i].e_cyc);
      chk($sformatf("v%0d_count", i), int'(vote_count), vt[i].e_nv);
    end
    // short press then re-press: one vote only, timed from the second press
    do_reset();
    button = 4'b0001;
    ticks(9);
    button = '0;
    tick();
    button = 4'b0001;
    ticks(40);
    button = '0;
    ticks(2);
    chk("repress_votes", nv, 1);
    chk("repress_cycle", vcyc, 21);
    chk("repress_id", vid, 0);
    // qualification inside lockout is dropped; re-press after lockout votes
    do_reset();
    button = 4'b0001;
    ticks(10);
    button = '0;
    ticks(5);
    button = 4'b0010;
    ticks(15);
    chk("lock_votes", nv, 1);
    chk("lock_conflicts", nc, 0);
    chk("lock_first_cycle", vcyc, 11);
    button = '0;
    ticks(2);
    button = 4'b0010;
    ticks(30);
    button = '0;
    chk("lock_votes2", nv, 2);
    chk("lock_id2", vid, 1);
    chk("lock_count2", int'(vote_count), 2);
    // other button rising during hold: conflict when exclusive, vote otherwise
    do_reset();
    button = 4'b0010;
    ticks(3);
    button = 4'b0011;
    ticks(9);
    button = 4'b0010;
    ticks(3);
    button = '0;
    ticks(20);
    chk("excl_conflicts", nc, 1);
    chk("excl_conflict_cycle", ccyc, 11);
    chk("excl_votes", nv, 0);
    chk("nonexcl_votes", nv_b, 1);
    chk("nonexcl_id", vid_b, 1);
    chk("nonexcl_conflicts", nc_b, 0);
    // asynchronous reset while the vote pulse is high
    do_reset();
    button = 4'b0100;
    ticks(11);
    chk("areset_pre_valid", int'(valid_vote), 1);
    chk("areset_pre_busy", int'(busy), 1);
    #2 reset = 1'b1;
    #1;
    chk("areset_valid", int'(valid_vote), 0);
    chk("areset_busy", int'(busy), 0);
    chk("areset_conflict", int'(conflict), 0);
    chk("areset_count", int'(vote_count), 0);
    @(negedge clock);
    reset = 1'b0;
    clr();
    ticks(12);
    enable = 1'b0;
    ticks(20);
    enable = 1'b1;
    button = '0;
    chk("after_reset_votes", nv, 1);
    chk("after_reset_cycle", vcyc, 11);
    chk("after_reset_count", int'(vote_count), 1);
    chk("disabled_lock_rundown", nb, 16);
    // enable dropped exactly in the qualification cycle
    do_reset();
    button = 4'b1000;
    ticks(10);
    enable = 1'b0;
    ticks(2);
    button = '0;
    enable = 1'b1;
    ticks(20);
    chk("en_drop_votes", nv, 0);
    chk("en_drop_conflicts", nc, 0);
    chk("en_drop_busy", nb, 0);
    chk("valid_and_conflict_overlap", both, 0);
    chk("vote_id_nonzero_idle", id_bad, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
